// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
//
// Sequencer for an in-place radix-2 decimation-in-time FFT held in a
// 2^N-point sample RAM. The transform runs in three phases:
//   LOAD    - accepts a stream of samples and writes each one at the
//             bit-reversed address of its arrival index.
//   COMPUTE - issues one butterfly per cycle, stage by stage. It drives the
//             operand addresses, the twiddle index and the write-back
//             addresses, which are delayed by the datapath latency.
//   FLUSH   - a BF_LAT-cycle gap after each stage. It lets every write-back
//             land before the next stage reads the RAM.
// A one-cycle DONE state then pulses 'done' and the controller returns to IDLE.
//
// Parameters
//   N       log2 of the FFT length
//   BF_LAT  cycles from butterfly read issue to write-back (>= 1)
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   start         begins a new transform; only acted on in IDLE
//   sample_valid  a source sample is present
//   sample_ready  high in LOAD only
//   load_we       RAM write strobe for a loaded sample
//   load_addr     bit-reversed RAM address for the current sample
//   bf_en         a butterfly read is issued this cycle
//   addr_a/addr_b top and bottom operand addresses
//   tw_addr       twiddle ROM index
//   stage         current butterfly stage, 0..N-1
//   wb_en         write-back strobe (bf_en delayed BF_LAT cycles)
//   wb_addr_a/b   addr_a/addr_b delayed BF_LAT cycles
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module fft_seq_ctrl #(
    parameter int N      = 9,
    parameter int BF_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     load_we,
    output logic [N-1:0]             load_addr,
    output logic                     bf_en,
    output logic [N-1:0]             addr_a,
    output logic [N-1:0]             addr_b,
    output logic [N-2:0]             tw_addr,
    output logic [$clog2(N+1)-1:0]   stage,
    output logic                     wb_en,
    output logic [N-1:0]             wb_addr_a,
    output logic [N-1:0]             wb_addr_b,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = $clog2(N+1);
    localparam int FW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    cnt_q, cnt_d;       // sample arrival index
    logic [N-2:0]    k_q, k_d;           // butterfly index within a stage
    logic [SW-1:0]   stage_q, stage_d;
    logic [FW-1:0]   flush_q, flush_d;   // cycles spent in FLUSH

    // -------------------------------------------------------------------------
    // Address arithmetic (combinational from stage_q / k_q / cnt_q)
    // -------------------------------------------------------------------------
    logic [N-1:0] cnt_rev;
    logic [N-1:0] k_ext;
    logic [N-1:0] span;
    logic [N-1:0] pos;
    logic [N-1:0] grp;
    logic [N-1:0] calc_a;
    logic [N-1:0] calc_b;
    logic [N-1:0] tw_full;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bitrev
            assign cnt_rev[gi] = cnt_q[N-1-gi];
        end
    endgenerate

    assign k_ext   = {1'b0, k_q};
    assign span    = N'(1) << stage_q;
    assign pos     = k_ext & (span - N'(1));
    assign grp     = k_ext >> stage_q;
    // The group index is spread out by 2*span, which leaves bit 'stage' of
    // addr_a clear. Adding span to form addr_b therefore never carries.
    assign calc_a  = ((grp << stage_q) << 1) | pos;
    assign calc_b  = calc_a + span;
    assign tw_full = pos << (SW'(N-1) - stage_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            stage_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            flush_q <= flush_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        stage_d = stage_q;
        flush_d = flush_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + N'(1);
                    if (&cnt_q) begin
                        state_d = S_COMPUTE;
                        k_d     = '0;
                        stage_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                k_d = k_q + (N-1)'(1);
                if (&k_q) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + FW'(1);
                // The last write-back of the stage lands in this final gap
                // cycle, so the next stage's first read sees it.
                if (flush_q == FW'(BF_LAT-1)) begin
                    flush_d = '0;
                    if (stage_q < SW'(N-1)) begin
                        state_d = S_COMPUTE;
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Addresses are forced to zero outside their active state.
    // -------------------------------------------------------------------------
    always_comb begin
        sample_ready = 1'b0;
        load_we      = 1'b0;
        load_addr    = '0;
        bf_en        = 1'b0;
        addr_a       = '0;
        addr_b       = '0;
        tw_addr      = '0;
        done         = 1'b0;
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                sample_ready = 1'b1;
                load_we      = sample_valid;
                load_addr    = cnt_rev;
            end
            S_COMPUTE: begin
                bf_en   = 1'b1;
                addr_a  = calc_a;
                addr_b  = calc_b;
                tw_addr = tw_full[N-2:0];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign stage = stage_q;

    // -------------------------------------------------------------------------
    // Write-back delay line: a BF_LAT-deep shift of bf_en/addr_a/addr_b.
    // It shifts every cycle, and reset flushes it so that butterflies issued
    // before the reset never produce a write-back strobe.
    // -------------------------------------------------------------------------
    logic [BF_LAT-1:0] wb_en_q, wb_en_d;
    logic [N-1:0]      wb_a_q [BF_LAT];
    logic [N-1:0]      wb_a_d [BF_LAT];
    logic [N-1:0]      wb_b_q [BF_LAT];
    logic [N-1:0]      wb_b_d [BF_LAT];

    generate
        for (genvar gi = 0; gi < BF_LAT; gi++) begin : g_wb_pipe
            if (gi == 0) begin : g_head
                assign wb_en_d[gi] = bf_en;
                assign wb_a_d[gi]  = addr_a;
                assign wb_b_d[gi]  = addr_b;
            end else begin : g_body
                assign wb_en_d[gi] = wb_en_q[gi-1];
                assign wb_a_d[gi]  = wb_a_q[gi-1];
                assign wb_b_d[gi]  = wb_b_q[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wb_en_q[gi] <= 1'b0;
                    wb_a_q[gi]  <= '0;
                    wb_b_q[gi]  <= '0;
                end else begin
                    wb_en_q[gi] <= wb_en_d[gi];
                    wb_a_q[gi]  <= wb_a_d[gi];
                    wb_b_q[gi]  <= wb_b_d[gi];
                end
            end
        end
    endgenerate

    assign wb_en     = wb_en_q[BF_LAT-1];
    assign wb_addr_a = wb_a_q[BF_LAT-1];
    assign wb_addr_b = wb_b_q[BF_LAT-1];

endmodule
